// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Game-wide object identifiers and overlay colours.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Object id produced by the pixel decoder; code 7 is unused/unknown.
    typedef enum logic [2:0] {
        OBJECT_NONE        = 3'd0,
        OBJECT_MAP         = 3'd1,
        OBJECT_BAR         = 3'd2,
        OBJECT_CAR1        = 3'd3,
        OBJECT_CAR2        = 3'd4,
        OBJECT_CAR1_CIRCLE = 3'd5,
        OBJECT_CAR2_CIRCLE = 3'd6
    } ObjectID;

    // Constant overlay colours, 24-bit RGB.
    localparam logic [23:0] CAR1_CIRCLE_RGB = 24'hFF8000;
    localparam logic [23:0] CAR2_CIRCLE_RGB = 24'h0080FF;

endpackage : game_pkg
`default_nettype wire

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : External SRAM layout: object base addresses and sprite sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Map is addressed as {v, h}; the pixel index is this wide.
    localparam int MAP_H_WIDTH = 9;
    localparam int MAP_V_WIDTH = 9;

    // Car sprites are square IMAGE_SIZE x IMAGE_SIZE, one frame per direction.
    localparam int          IMAGE_SIZE      = 32;
    localparam int unsigned CAR_FRAME_WORDS = IMAGE_SIZE * IMAGE_SIZE;
    localparam int          CAR_DIRS        = 16;

    // Word base addresses of each SRAM-backed object.
    localparam int unsigned MAP_BASE  = 32'h0_0000;
    localparam int unsigned BAR_BASE  = 32'h4_0000;
    localparam int unsigned CAR1_BASE = 32'h8_0000;
    localparam int unsigned CAR2_BASE = 32'h8_4000;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/rgb565_expand.sv
`default_nettype none
// ============================================================================
// Module      : rgb565_expand
// Description : RGB565 to RGB888 by MSB replication (full-scale maps to FF).
// Revision    : 1.0 - initial release
// ============================================================================
module rgb565_expand (
    input  logic [15:0] i_rgb565,
    output logic [23:0] o_rgb888
);

    logic [4:0] w_r5;
    logic [5:0] w_g6;
    logic [4:0] w_b5;

    assign w_r5 = i_rgb565[15:11];
    assign w_g6 = i_rgb565[10:5];
    assign w_b5 = i_rgb565[4:0];

    assign o_rgb888 = {w_r5, w_r5[4:2], w_g6, w_g6[5:4], w_b5, w_b5[4:2]};

endmodule : rgb565_expand
`default_nettype wire

// File: rtl/frame_pixel_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : frame_pixel_fetcher
// Description : Three-stage pixel colour fetch: object id/index -> SRAM
//               address -> SRAM data -> RGB888, with sync/blank delayed to
//               stay aligned with the colour.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pixel_fetcher
    import sram_pkg::*;
    import game_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = MAP_H_WIDTH + MAP_V_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_frame_start,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    input  logic                  i_blank_n,
    input  ObjectID               i_object_id,
    input  logic [IDX_WIDTH-1:0]  i_pixel_index,
    input  logic [3:0]            i_car1_dir,
    input  logic [3:0]            i_car2_dir,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    input  logic [DATA_WIDTH-1:0] i_sram_dq,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n,
    output logic [7:0]            o_r,
    output logic [7:0]            o_g,
    output logic [7:0]            o_b,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_blank_n
);

    localparam int c_dir_w = $clog2(CAR_DIRS);

    // Constant-colour selector carried in the tag.
    localparam logic [1:0] c_sel_black = 2'd0;
    localparam logic [1:0] c_sel_car1  = 2'd1;
    localparam logic [1:0] c_sel_car2  = 2'd2;

    typedef struct packed {
        logic       is_const;
        logic [1:0] const_sel;
        logic       blank_n;
        logic       hsync;
        logic       vsync;
    } tag_t;

    // Cleared tag: blanked pixel with both syncs inactive (high).
    localparam tag_t c_tag_reset = '{is_const: 1'b0, const_sel: 2'd0,
                                     blank_n: 1'b0, hsync: 1'b1, vsync: 1'b1};

    logic [c_dir_w-1:0]    r_car1_dir;
    logic [c_dir_w-1:0]    r_car2_dir;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic                  r_sram_oe_n;
    tag_t                  r_tag1;
    tag_t                  r_tag2;
    logic [DATA_WIDTH-1:0] r_sram_data;
    logic [23:0]           r_rgb;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_blank_n;

    logic [ADDR_WIDTH-1:0] w_next_addr;
    tag_t                  w_tag;
    logic [23:0]           w_expanded;
    logic [23:0]           w_rgb;

    // Car directions only change at frame start so sprites cannot tear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_car1_dir <= '0;
            r_car2_dir <= '0;
        end else if (i_frame_start) begin
            r_car1_dir <= c_dir_w'(i_car1_dir);
            r_car2_dir <= c_dir_w'(i_car2_dir);
        end
    end

    // Address generation and tag build; non-SRAM ids keep the last address.
    always_comb begin
        w_next_addr       = r_sram_addr;
        w_tag.is_const    = 1'b1;
        w_tag.const_sel   = c_sel_black;
        w_tag.blank_n     = i_blank_n;
        w_tag.hsync       = i_hsync;
        w_tag.vsync       = i_vsync;
        case (i_object_id)
            OBJECT_MAP: begin
                w_next_addr    = ADDR_WIDTH'(MAP_BASE) + ADDR_WIDTH'(i_pixel_index);
                w_tag.is_const = 1'b0;
            end
            OBJECT_BAR: begin
                w_next_addr    = ADDR_WIDTH'(BAR_BASE) + ADDR_WIDTH'(i_pixel_index);
                w_tag.is_const = 1'b0;
            end
            OBJECT_CAR1: begin
                w_next_addr    = ADDR_WIDTH'(CAR1_BASE)
                               + ADDR_WIDTH'(r_car1_dir) * ADDR_WIDTH'(CAR_FRAME_WORDS)
                               + ADDR_WIDTH'(i_pixel_index);
                w_tag.is_const = 1'b0;
            end
            OBJECT_CAR2: begin
                w_next_addr    = ADDR_WIDTH'(CAR2_BASE)
                               + ADDR_WIDTH'(r_car2_dir) * ADDR_WIDTH'(CAR_FRAME_WORDS)
                               + ADDR_WIDTH'(i_pixel_index);
                w_tag.is_const = 1'b0;
            end
            OBJECT_CAR1_CIRCLE: w_tag.const_sel = c_sel_car1;
            OBJECT_CAR2_CIRCLE: w_tag.const_sel = c_sel_car2;
            default: ;
        endcase
    end

    // Stage 1: present address to SRAM, launch tag; OE asserts after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sram_addr <= '0;
            r_sram_oe_n <= 1'b1;
            r_tag1      <= c_tag_reset;
        end else begin
            r_sram_addr <= w_next_addr;
            r_sram_oe_n <= 1'b0;
            r_tag1      <= w_tag;
        end
    end

    // Stage 2: capture asynchronous SRAM data after a full cycle of settling.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sram_data <= '0;
            r_tag2      <= c_tag_reset;
        end else begin
            r_sram_data <= i_sram_dq;
            r_tag2      <= r_tag1;
        end
    end

    rgb565_expand u_rgb565_expand (
        .i_rgb565 (r_sram_data),
        .o_rgb888 (w_expanded)
    );

    // Colour resolve: blanking wins, then constant overlays, then SRAM data.
    always_comb begin
        w_rgb = 24'h000000;
        if (r_tag2.blank_n) begin
            if (!r_tag2.is_const) begin
                w_rgb = w_expanded;
            end else begin
                case (r_tag2.const_sel)
                    c_sel_car1: w_rgb = CAR1_CIRCLE_RGB;
                    c_sel_car2: w_rgb = CAR2_CIRCLE_RGB;
                    default:    w_rgb = 24'h000000;
                endcase
            end
        end
    end

    // Stage 3: register colour together with the delayed sync/blank.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb     <= 24'h000000;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_rgb     <= w_rgb;
            r_hsync   <= r_tag2.hsync;
            r_vsync   <= r_tag2.vsync;
            r_blank_n <= r_tag2.blank_n;
        end
    end

    assign o_sram_addr = r_sram_addr;
    assign o_sram_oe_n = r_sram_oe_n;
    assign o_sram_we_n = 1'b1;
    assign o_r         = r_rgb[23:16];
    assign o_g         = r_rgb[15:8];
    assign o_b         = r_rgb[7:0];
    assign o_hsync     = r_hsync;
    assign o_vsync     = r_vsync;
    assign o_blank_n   = r_blank_n;

endmodule : frame_pixel_fetcher
`default_nettype wire

// File: tb/tb_frame_pixel_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_pixel_fetcher
// Description : Directed self-checking bench for frame_pixel_fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_pixel_fetcher;
    import sram_pkg::*;
    import game_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int IW = MAP_H_WIDTH + MAP_V_WIDTH;
    localparam int N  = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          hsync, vsync, blank_n;
    ObjectID       object_id;
    logic [IW-1:0] pixel_index;
    logic [3:0]    car1_dir, car2_dir;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq;
    logic          sram_oe_n, sram_we_n;
    logic [7:0]    r, g, b;
    logic          o_hs, o_vs, o_bn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_pixel_fetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .i_blank_n     (blank_n),
        .i_object_id   (object_id),
        .i_pixel_index (pixel_index),
        .i_car1_dir    (car1_dir),
        .i_car2_dir    (car2_dir),
        .o_sram_addr   (sram_addr),
        .i_sram_dq     (sram_dq),
        .o_sram_oe_n   (sram_oe_n),
        .o_sram_we_n   (sram_we_n),
        .o_r           (r),
        .o_g           (g),
        .o_b           (b),
        .o_hsync       (o_hs),
        .o_vsync       (o_vs),
        .o_blank_n     (o_bn)
    );

    // Asynchronous SRAM contents: two known words, the rest a hash of the address.
    function automatic logic [15:0] sram_word(input logic [AW-1:0] a);
        if (a == 20'h00005) return 16'hF800;
        if (a == 20'h40000) return 16'h07E0;
        return (a[15:0] * 16'h9E37) ^ {12'h5A5, a[19:16]};
    endfunction

    always_comb sram_dq = sram_word(sram_addr);

    function automatic logic [23:0] expand(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ObjectID id, input logic [IW-1:0] idx, input logic bn,
                         input logic hs, input logic vs);
        object_id   = id;
        pixel_index = idx;
        blank_n     = bn;
        hsync       = hs;
        vsync       = vs;
    endtask

    ObjectID       id_tbl [9];
    logic [26:0]   exp_q  [N];
    logic [AW-1:0] m_addr;
    logic [3:0]    m_dir1, m_dir2;

    initial begin
        id_tbl = '{OBJECT_MAP, OBJECT_CAR1, OBJECT_CAR1_CIRCLE, OBJECT_MAP, OBJECT_BAR,
                   OBJECT_CAR2, OBJECT_CAR2_CIRCLE, ObjectID'(3'd7), OBJECT_NONE};

        // ---- reset with random inputs ----
        rst_n       = 1'b0;
        frame_start = 1'($urandom_range(0, 1));
        car1_dir    = 4'($urandom_range(0, 15));
        car2_dir    = 4'($urandom_range(0, 15));
        drive(ObjectID'($urandom_range(0, 7)), IW'($urandom), 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check_eq("rst_addr",  32'(sram_addr), 32'h0);
        check_eq("rst_oe_n",  32'(sram_oe_n), 32'h1);
        check_eq("rst_we_n",  32'(sram_we_n), 32'h1);
        check_eq("rst_rgb",   32'({r, g, b}), 32'h0);
        check_eq("rst_sync",  32'({o_hs, o_vs, o_bn}), 32'b110);

        // ---- release: three blank cycles, then the map pixel ----
        frame_start = 1'b0;
        car1_dir    = 4'd0;
        car2_dir    = 4'd0;
        drive(OBJECT_MAP, IW'(5), 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        tick();
        check_eq("map_addr",   32'(sram_addr), 32'h00005);
        check_eq("rel_blank1", 32'(o_bn), 32'h0);
        check_eq("oe_active",  32'(sram_oe_n), 32'h0);
        tick();
        check_eq("rel_blank2", 32'(o_bn), 32'h0);
        tick();
        check_eq("map_blank_n", 32'(o_bn), 32'h1);
        check_eq("map_rgb",     32'({r, g, b}), 32'hFF0000);

        // ---- car direction latch ----
        car1_dir    = 4'd3;
        car2_dir    = 4'd15;
        frame_start = 1'b1;
        drive(OBJECT_NONE, IW'(0), 1'b1, 1'b1, 1'b1);
        tick();
        frame_start = 1'b0;
        drive(OBJECT_CAR1, IW'(10), 1'b1, 1'b1, 1'b1);
        tick();
        check_eq("car1_addr", 32'(sram_addr), 32'h80C0A);
        car1_dir = 4'd7;
        tick();
        check_eq("car1_nolatch", 32'(sram_addr), 32'h80C0A);
        tick();
        check_eq("car1_rgb", 32'({r, g, b}), 32'(expand(sram_word(20'h80C0A))));
        car1_dir    = 4'd5;
        frame_start = 1'b1;
        tick();
        check_eq("car1_samecyc", 32'(sram_addr), 32'h80C0A);
        frame_start = 1'b0;
        tick();
        check_eq("car1_newdir", 32'(sram_addr), 32'h8140A);
        drive(OBJECT_CAR2, IW'(10'h3FF), 1'b1, 1'b1, 1'b1);
        tick();
        check_eq("car2_addr", 32'(sram_addr), 32'h87FFF);

        // ---- circle overlay and blanking ----
        drive(OBJECT_CAR2_CIRCLE, IW'(77), 1'b1, 1'b1, 1'b1);
        tick();
        check_eq("circ_addr_hold", 32'(sram_addr), 32'h87FFF);
        tick();
        tick();
        check_eq("circ2_rgb", 32'({r, g, b}), 32'h0080FF);
        drive(OBJECT_CAR2_CIRCLE, IW'(77), 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        check_eq("circ2_blank_rgb", 32'({r, g, b}), 32'h0);
        check_eq("circ2_blank_n",   32'(o_bn), 32'h0);

        // ---- bar pixel, then mid-line reset ----
        drive(OBJECT_BAR, IW'(0), 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("bar_addr", 32'(sram_addr), 32'h40000);
        tick();
        tick();
        check_eq("bar_rgb",   32'({r, g, b}), 32'h00FF00);
        check_eq("bar_hsync", 32'(o_hs), 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rgb",  32'({r, g, b}), 32'h0);
        check_eq("midrst_sync", 32'({o_hs, o_vs, o_bn}), 32'b110);
        check_eq("midrst_addr", 32'(sram_addr), 32'h0);
        check_eq("midrst_oe_n", 32'(sram_oe_n), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- alignment over a line of mixed ids against a reference model ----
        m_addr = '0;
        m_dir1 = '0;
        m_dir2 = '0;
        for (int i = 0; i < N + 2; i++) begin
            if (i < N) begin
                logic [IW-1:0] idx;
                logic          bn, hs, vs;
                logic [23:0]   rgb;
                ObjectID       id;
                id  = id_tbl[i % 9];
                idx = IW'(i * 1237 + 3);
                bn  = (i % 16) < 11;
                hs  = !((i % 16) >= 12 && (i % 16) < 14);
                vs  = !(i >= 30 && i < 34);
                car1_dir    = 4'(i);
                car2_dir    = 4'(15 - i);
                frame_start = (i == 20);
                drive(id, idx, bn, hs, vs);
                rgb = 24'h0;
                case (id)
                    OBJECT_MAP:  m_addr = AW'(MAP_BASE) + AW'(idx);
                    OBJECT_BAR:  m_addr = AW'(BAR_BASE) + AW'(idx);
                    OBJECT_CAR1: m_addr = AW'(CAR1_BASE) + AW'(m_dir1) * AW'(1024) + AW'(idx);
                    OBJECT_CAR2: m_addr = AW'(CAR2_BASE) + AW'(m_dir2) * AW'(1024) + AW'(idx);
                    default: ;
                endcase
                if (bn) begin
                    case (id)
                        OBJECT_MAP, OBJECT_BAR, OBJECT_CAR1, OBJECT_CAR2:
                            rgb = expand(sram_word(m_addr));
                        OBJECT_CAR1_CIRCLE: rgb = 24'hFF8000;
                        OBJECT_CAR2_CIRCLE: rgb = 24'h0080FF;
                        default: rgb = 24'h0;
                    endcase
                end
                exp_q[i] = {rgb, hs, vs, bn};
                if (frame_start) begin
                    m_dir1 = car1_dir;
                    m_dir2 = car2_dir;
                end
            end else begin
                frame_start = 1'b0;
                drive(OBJECT_NONE, IW'(0), 1'b0, 1'b1, 1'b1);
            end
            tick();
            if (i >= 2) begin
                check_eq($sformatf("align[%0d]", i - 2),
                         32'({r, g, b, o_hs, o_vs, o_bn}), 32'(exp_q[i - 2]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_frame_pixel_fetcher
`default_nettype wire

// File: doc/frame_pixel_fetcher.md
# frame_pixel_fetcher

Pipelined stage directly downstream of the pixel decoder. It takes the per-pixel object id and pixel index and resolves them to 24-bit RGB for the VGA DAC. SRAM-backed objects (map, bar, car sprites) are read from the external 16-bit SRAM; circle overlays get constant colours. VGA sync and blank signals are delayed so they stay aligned with the colour output.

## Interface
Parameters:
- ADDR_WIDTH, 20, SRAM word-address width
- DATA_WIDTH, 16, SRAM data width (RGB565)
- IDX_WIDTH, sram_pkg::MAP_H_WIDTH+sram_pkg::MAP_V_WIDTH, pixel index width

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse at start of vertical blank
- i_hsync  in  1  VGA hsync, active-low, aligned with i_object_id
- i_vsync  in  1  VGA vsync, active-low, aligned
- i_blank_n  in  1  high on visible pixels, aligned
- i_object_id  in  game_pkg::ObjectID  object from pixel decoder
- i_pixel_index  in  IDX_WIDTH  index within object
- i_car1_dir  in  4  car1 rotation frame, 0..15
- i_car2_dir  in  4  car2 rotation frame, 0..15
- o_sram_addr  out  ADDR_WIDTH  SRAM word address (registered)
- i_sram_dq  in  DATA_WIDTH  SRAM read data
- o_sram_oe_n  out  1  SRAM output enable, active-low
- o_sram_we_n  out  1  tied high (read-only block)
- o_r, o_g, o_b  out  8 each  colour to DAC
- o_hsync, o_vsync, o_blank_n  out  1 each  delayed sync/blank

## Operation
- Direction latch: car1_dir_q and car2_dir_q capture i_carN_dir only on cycles with i_frame_start=1. They hold for the whole frame, so sprites cannot tear mid-frame. Reset value is 0.
- Address map (sram_pkg constants), computed modulo 2^ADDR_WIDTH:
  - OBJECT_MAP: MAP_BASE + index
  - OBJECT_BAR: BAR_BASE + index
  - OBJECT_CAR1: CAR1_BASE + car1_dir_q*CAR_FRAME_WORDS + index, with CAR_FRAME_WORDS = IMAGE_SIZE*IMAGE_SIZE
  - OBJECT_CAR2: CAR2_BASE + car2_dir_q*CAR_FRAME_WORDS + index
  - Circle ids: address held at its previous value; no read is consumed.
- Per-pixel tag travels down the pipe with the address. The tag is {is_const, const_colour_sel, blank_n, hsync, vsync}.
- Colour resolve:
  - SRAM objects: RGB565 is expanded by bit replication: r8={r5,r5[4:2]}, g8={g6,g6[5:4]}, b8={b5,b5[4:2]}.
  - OBJECT_CAR1_CIRCLE outputs CAR1_CIRCLE_RGB; OBJECT_CAR2_CIRCLE outputs CAR2_CIRCLE_RGB.
  - Unknown id outputs 24'h000000.
  - blank_n=0 forces the output to 24'h000000, whatever the id.
- o_sram_oe_n is low whenever out of reset. o_sram_we_n is constant 1.

## Timing
- The pipeline runs every cycle with no stall and no handshake.
- Edge 1: register address and tag. o_sram_addr changes here.
- Edge 2: capture i_sram_dq. The SRAM is asynchronous and has a full cycle to settle.
- Edge 3: register RGB and delayed sync/blank.
- Total latency: exactly 3 cycles, input to o_r/o_g/o_b, for every id. Sync and blank are delayed by the same 3 cycles.
- A pulse on i_frame_start at cycle t affects addresses presented at t+1 onward. A car pixel presented in the same cycle as the pulse uses the old direction.
- Reset values:
  - o_sram_addr=0, o_sram_oe_n=1
  - o_r=o_g=o_b=0
  - o_hsync=1, o_vsync=1, o_blank_n=0
  - all pipeline tags are cleared to blank_n=0, hsync=1, vsync=1
- Reset asserted mid-line: outputs go to reset values immediately (asynchronous). After release, the first 3 output cycles show blank.
- Back-to-back object changes, e.g. map→car1→circle→map on consecutive cycles, must each resolve independently with no bubble.

## Structure
- sram_pkg holds: MAP_BASE, BAR_BASE, CAR1_BASE, CAR2_BASE, CAR_FRAME_WORDS, CAR_DIRS=16.
- game_pkg holds: CAR1_CIRCLE_RGB, CAR2_CIRCLE_RGB, and the existing ObjectID.
- Sub-module rgb565_expand: pure combinational, 16-bit in, 24-bit out.
- The address generation stage and the tag delay line stay inline.

## Test plan
- Reset: hold i_rst_n=0 with random inputs -> outputs at reset values. Release -> 3 blank cycles, then data.
- Map pixel: id=MAP, index=5, blank_n=1, SRAM model returns 16'hF800 at MAP_BASE+5 -> o_sram_addr=MAP_BASE+5 after 1 cycle; RGB=FF/00/00 after 3 cycles.
- Car1 direction latch: i_car1_dir=3, frame_start pulse, id=CAR1, index=10 -> addr=CAR1_BASE+3*CAR_FRAME_WORDS+10. Change dir to 7 with no pulse -> address unchanged.
- Circles and blank:
  - id=CAR2_CIRCLE -> CAR2_CIRCLE_RGB at +3 cycles, o_sram_addr holds.
  - Same id with blank_n=0 -> 000000.
- Alignment: drive hsync/vsync patterns over a full line of mixed ids -> o_hsync/o_vsync/o_blank_n equal the inputs delayed exactly 3 cycles, and colour matches the per-cycle reference model.
- Bar pixel: id=BAR, index=0 with 16'h07E0 -> RGB 00/FF/00. Mid-line reset -> immediate black and sync=1.
